prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Program loader that writes instruction words into the instruction memory, which the CPU fetch stage then reads. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written through the instruction memory write port at incrementing addresses. The CPU is held (cpu_hold) until a checksum-verified image is fully written.

Parameters:
BASE_ADDR, 0, address of the first written word
ADDR_STEP, 1, address increment per word (instruction memory is word-addressed)
MAX_WORDS, 1024, largest accepted word count; larger headers are errors

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; arms a load from IDLE, DONE or ERROR
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  loader can accept a byte this cycle
imem_wr_en  out  1  one-cycle instruction memory write strobe
imem_wr_addr  out  32  write address
imem_wr_data  out  32  write data, big-endian assembled word
cpu_hold  out  1  holds the CPU pipeline/PC; low only in DONE
busy  out  1  load in progress (LEN_HI..CSUM)
done  out  1  image loaded and checksum matched
err  out  1  load failed (length or checksum)
words_loaded  out  16  count of words written in the current load

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst) and wins over every other input.
- Reset values: state=IDLE, in_ready=0, imem_wr_en=0, imem_wr_addr=BASE_ADDR, imem_wr_data=0, cpu_hold=1, busy=0, done=0, err=0, words_loaded=0, checksum=0, byte index=0.
- Byte transfer: occurs on any cycle with in_valid & in_ready. in_ready is combinational from state only: 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 elsewhere.
- Stream format: count_hi, count_lo, then 4*count payload bytes (MSB first per word), then one checksum byte.
- Checksum: XOR of every byte preceding it, including both count bytes.
- States:
  - IDLE: start -> LEN_HI, clearing checksum, words_loaded and byte index; imem_wr_addr=BASE_ADDR.
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte; if count==0 -> CSUM; if count>MAX_WORDS -> ERROR; else -> DATA.
  - DATA: accept bytes into a shift register. On the 4th byte of a word, register the word. Next cycle: imem_wr_en=1, imem_wr_addr=current address, imem_wr_data=word. After the strobe, the address advances by ADDR_STEP and words_loaded increments. After the last word's 4th byte -> CSUM.
  - CSUM: accept byte; if it equals the running XOR -> DONE, else -> ERROR.
  - DONE: done=1, cpu_hold=0; start -> LEN_HI (done clears, cpu_hold=1).
  - ERROR: err=1, cpu_hold=1; start -> LEN_HI (err clears).
- start is ignored while busy=1.
- Write latency: exactly 1 cycle after the accepting edge of a word's last byte.
- Back-to-back bytes at full rate are supported; imem_wr_en is never asserted on two consecutive cycles except when words complete on consecutive 4-byte boundaries (impossible at 1 byte/cycle).
- Stalls: in_valid low mid-word keeps the partial word and byte index unchanged for any duration.
- Address wrap: arithmetic is 32-bit modulo 2^32, with no special handling.
- Reset mid-load: the partial word is discarded and no write is issued. Memory contents already written remain.
- Simultaneous rst and start: reset wins.
- The last word's write strobe fires in the cycle the FSM enters CSUM, so it is still issued if the checksum byte is accepted in that same cycle.

Decomposition:
- Shared package (loader_pkg): state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR); stream byte width 8; word width 32; count width 16.
- Sub-module byte_packer:
  - Inputs: shift enable, clear, byte.
  - Outputs: 32-bit word, word_complete pulse, 2-bit byte index.
  - Owns the big-endian assembly.
- The top owns the FSM, checksum, address counter and write strobe register.

Test Plan:
1. Reset, start, stream 00 02 | 12 34 56 78 | 9A BC DE F0 | csum 00^02^12^34^56^78^9A^BC^DE^F0=02 -> writes 0x12345678@0 and 0x9ABCDEF0@1, each 1 cycle after its 4th byte; done=1, cpu_hold=0, words_loaded=2.
2. Same stream with checksum 0x03 -> ERROR: err=1, cpu_hold=1, done=0, the two writes still issued; a new start re-arms to LEN_HI with err=0.
3. Header 04 01 (1025 > MAX_WORDS) -> ERROR after the 2nd byte, in_ready=0, no writes.
4. Header 00 00, checksum 00 -> DONE with zero writes; checksum 01 -> ERROR.
5. One-word load with in_valid toggling 1,0,0,1,0,1,1 mid-word -> single write 0xAABBCCDD correct; in_ready unaffected by the stall.
6. rst asserted after 2 payload bytes -> no write, all outputs at reset values; a subsequent start loads a full image from BASE_ADDR.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader.
package loader_pkg;
  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int COUNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if;
  import loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              imem_wr_en;
  logic [WORD_W-1:0] imem_wr_addr;
  logic [WORD_W-1:0] imem_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/byte_packer.sv
// Big-endian word assembly: three held bytes plus the byte being accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_complete,
  output logic [1:0]        byte_idx
);
  logic [WORD_W-BYTE_W-1:0] hold;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold     <= '0;
      byte_idx <= '0;
    end else if (shift_en) begin
      hold     <= {hold[WORD_W-2*BYTE_W-1:0], data_byte};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // word is only meaningful in the cycle word_complete is high
  assign word          = {hold, data_byte};
  assign word_complete = shift_en && (byte_idx == 2'd3);
endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory
// and holds the CPU until a verified image has been written.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LEN_HI | expecting word-count high byte
//   LEN_LO | expecting word-count low byte, range check
//   DATA   | accepting payload bytes, one write per 4 bytes
//   CSUM   | expecting checksum byte
//   DONE   | image verified, CPU released
//   ERROR  | bad length or checksum, CPU held
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = '0,
  parameter logic [WORD_W-1:0] ADDR_STEP = 32'd1,
  parameter int                MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  prog_loader_if.slave       bus,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] words_loaded
);
  localparam logic [31:0] MAX_W32 = MAX_WORDS;

  state_t              state, state_nxt;
  logic                xfer, arm, shift_en, word_complete, last_word;
  logic [1:0]          byte_idx;
  logic [WORD_W-1:0]   word;
  logic [BYTE_W-1:0]   csum, count_hi;
  logic [COUNT_W-1:0]  count, words_left;
  logic                wr_en;
  logic [WORD_W-1:0]   wr_addr, wr_data;

  assign xfer      = bus.in_valid & bus.in_ready;
  assign count     = {count_hi, bus.in_data};
  assign arm       = start && (state == IDLE || state == DONE || state == ERROR);
  assign shift_en  = xfer && (state == DATA);
  assign last_word = shift_en && (byte_idx == 2'd3) && (words_left == 16'd1);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (shift_en),
    .clear        (arm),
    .data_byte    (bus.in_data),
    .word         (word),
    .word_complete(word_complete),
    .byte_idx     (byte_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = LEN_HI;
      LEN_HI: if (xfer) state_nxt = LEN_LO;
      LEN_LO: if (xfer) begin
        if (count == '0)                  state_nxt = CSUM;
        else if ({16'd0, count} > MAX_W32) state_nxt = ERROR;
        else                              state_nxt = DATA;
      end
      DATA: if (last_word) state_nxt = CSUM;
      CSUM: if (xfer) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    cpu_hold     = 1'b1;
    unique case (state)
      LEN_HI, LEN_LO, DATA, CSUM: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR:   err = 1'b1;
      default: ;
    endcase
  end

  // words_left counts down to the terminal word; the write strobe lags the
  // 4th byte by one cycle and the address/count advance after the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      csum         <= '0;
      count_hi     <= '0;
      words_left   <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= BASE_ADDR;
      wr_data      <= '0;
      words_loaded <= '0;
    end else begin
      wr_en <= word_complete;
      if (word_complete) wr_data <= word;
      if (arm) begin
        csum         <= '0;
        words_loaded <= '0;
        wr_addr      <= BASE_ADDR;
      end else begin
        if (xfer && state != CSUM) csum <= csum ^ bus.in_data;
        if (wr_en) begin
          wr_addr      <= wr_addr + ADDR_STEP;
          words_loaded <= words_loaded + 16'd1;
        end
      end
      if (xfer && state == LEN_HI) count_hi <= bus.in_data;
      if (xfer && state == LEN_LO) words_left <= count;
      else if (word_complete)      words_left <= words_left - 16'd1;
    end
  end

  assign bus.imem_wr_en   = wr_en;
  assign bus.imem_wr_addr = wr_addr;
  assign bus.imem_wr_data = wr_data;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: the driver pushes expected
// writes as 4th bytes are accepted, a monitor pops them on each write strobe.
module tb_prog_loader;
  import loader_pkg::*;

  localparam logic [31:0] BASE = 32'd0;
  localparam logic [31:0] STEP = 32'd1;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        cpu_hold, busy, done, err;
  logic [15:0] words_loaded;

  prog_loader_if bus ();

  prog_loader #(.BASE_ADDR(BASE), .ADDR_STEP(STEP), .MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus.slave),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bus.imem_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h expected none",
                 bus.imem_wr_addr, bus.imem_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bus.imem_wr_addr, mon_e.addr);
        chk("wr_data", bus.imem_wr_data, mon_e.data);
        chk("wr_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en", bus.imem_wr_en, 0);
    chk("rst_wr_addr", bus.imem_wr_addr, BASE);
    chk("rst_wr_data", bus.imem_wr_data, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words_loaded", words_loaded, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte after 'gap' idle cycles; returns the negedge cycle at which
  // the byte was presented with in_ready high (it is accepted on the next edge).
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok, output int acc);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ready_during_stall", bus.in_ready, 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual in_ready=0 expected 1");
      bus.in_valid = 1'b0;
      ok = 1'b0;
      acc = 0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    ok = 1'b1;
  endtask

  // gap_mode: 0 full rate, 1 random stalls, 2 fixed valid pattern 1,0,0,1,0,1,1
  task automatic run_load(input logic [31:0] words[$], input int count, input logic [7:0] delta,
                          input int gap_mode, input bit poke);
    logic [7:0] x, b;
    bit         ok, good;
    int         acc, gap;
    int         fixed_gaps[4] = '{0, 2, 1, 0};
    logic [15:0] cnt16;
    cnt16 = 16'(count);
    pulse_start();
    chk("arm_busy", busy, 1);
    chk("arm_in_ready", bus.in_ready, 1);
    chk("arm_err", err, 0);
    chk("arm_done", done, 0);
    chk("arm_cpu_hold", cpu_hold, 1);
    chk("arm_words_loaded", words_loaded, 0);

    send_byte(cnt16[15:8], 0, ok, acc);
    if (!ok) return;
    send_byte(cnt16[7:0], 0, ok, acc);
    if (!ok) return;
    x = cnt16[15:8] ^ cnt16[7:0];

    if (count > MAXW) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("len_err", err, 1);
      chk("len_in_ready", bus.in_ready, 0);
      chk("len_cpu_hold", cpu_hold, 1);
      chk("len_done", done, 0);
      repeat (3) @(negedge clk);
      chk("len_no_writes", 32'(exp_q.size()), 0);
      return;
    end

    for (int i = 0; i < count; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = words[i][31-8*j -: 8];
        x ^= b;
        if (poke && i == 0 && j == 2) begin
          pulse_start();
          chk("start_ignored_busy", busy, 1);
        end
        gap = (gap_mode == 1) ? int'($urandom_range(0, 2)) : (gap_mode == 2) ? fixed_gaps[j] : 0;
        send_byte(b, gap, ok, acc);
        if (!ok) return;
        if (j == 3) exp_q.push_back('{BASE + STEP * 32'(i), words[i], acc + 1});
      end
    end

    good = (delta == 8'h00);
    send_byte(x ^ delta, 0, ok, acc);
    if (!ok) return;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("end_done", done, 32'(good));
    chk("end_err", err, 32'(!good));
    chk("end_cpu_hold", cpu_hold, 32'(!good));
    chk("end_busy", busy, 0);
    chk("end_in_ready", bus.in_ready, 0);
    chk("end_words_loaded", words_loaded, 32'(count));
    repeat (2) @(negedge clk);
    chk("end_writes_drained", 32'(exp_q.size()), 0);
  endtask

  logic [31:0] wq[$];
  logic [31:0] none_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    ok;
    int    acc, n;
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // 1: two-word image, good checksum (0x02)
    wq = '{32'h12345678, 32'h9ABCDEF0};
    run_load(wq, 2, 8'h00, 0, 1'b0);
    // 2: same image, checksum 0x03
    run_load(wq, 2, 8'h01, 0, 1'b0);
    // 3: header over MAX_WORDS
    run_load(none_q, 1025, 8'h00, 0, 1'b0);
    // 4: empty image, good then bad checksum
    run_load(none_q, 0, 8'h00, 0, 1'b0);
    run_load(none_q, 0, 8'h01, 0, 1'b0);
    // 5: one word with mid-word stalls and an ignored start
    wq = '{32'hAABBCCDD};
    run_load(wq, 1, 8'h00, 2, 1'b1);

    // 6: reset after two payload bytes
    pulse_start();
    send_byte(8'h00, 0, ok, acc);
    send_byte(8'h01, 0, ok, acc);
    send_byte(8'h11, 0, ok, acc);
    send_byte(8'h22, 0, ok, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_pending", 32'(exp_q.size()), 0);
    wq = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h00000001};
    run_load(wq, 3, 8'h00, 0, 1'b0);

    // randomized loads
    for (int k = 0; k < 10; k++) begin
      n = int'($urandom_range(1, 6));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_load(wq, n, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
               1, 1'($urandom_range(0, 1)));
    end

    // boundary: exactly MAX_WORDS words
    wq.delete();
    for (int i = 0; i < MAXW; i++) wq.push_back($urandom);
    run_load(wq, MAXW, 8'h00, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
